// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters that stall decode on RAW and capacity hazards.
module reg_scoreboard #(
    parameter int NREGS   = 15,
    parameter int MAXPEND = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             use_src2,
    input  logic             wr_en,
    input  logic [3:0]       dest,
    output logic             issue_ready,
    output logic             stall,
    input  logic             wb_valid,
    input  logic [3:0]       wb_dest,
    input  logic             flush,
    output logic [NREGS-1:0] busy_mask,
    output logic [5:0]       inflight,
    output logic             underflow_err
);
    logic [1:0]       cnt_q [NREGS];
    logic [1:0]       cnt_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [5:0]       inflight_q, inflight_d;
    logic             uf_q, uf_d;
    logic             src_haz, cap_haz;
    always_comb begin
        src_haz = 1'b0;
        cap_haz = 1'b0;
        // Index 15 never matches any i, so PC is naturally excluded.
        for (int i = 0; i < NREGS; i++) begin
            src_haz = src_haz | ((src1 == 4'(i) || (use_src2 && src2 == 4'(i))) && cnt_q[i] != 2'd0
                      && !(wb_valid && wb_dest == 4'(i) && cnt_q[i] == 2'd1));
            cap_haz = cap_haz | (wr_en && dest == 4'(i) && cnt_q[i] == 2'(MAXPEND)
                      && !(wb_valid && wb_dest == 4'(i)));
        end
    end
    assign stall       = issue_valid && (src_haz || cap_haz);
    assign issue_ready = issue_valid && !stall;
    always_comb begin
        uf_d       = uf_q;
        inflight_d = 6'd0;
        busy_d     = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_d[i] = flush ? 2'd0
                     : (issue_ready && wr_en && dest == 4'(i)) && !(wb_valid && wb_dest == 4'(i)) ? cnt_q[i] + 2'd1
                     : !(issue_ready && wr_en && dest == 4'(i)) && (wb_valid && wb_dest == 4'(i)) && cnt_q[i] != 2'd0 ? cnt_q[i] - 2'd1
                     : cnt_q[i];
            uf_d       = uf_d | (wb_valid && wb_dest == 4'(i) && cnt_q[i] == 2'd0);
            inflight_d = inflight_d + 6'(cnt_d[i]);
            busy_d[i]  = cnt_d[i] != 2'd0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) cnt_q[i] <= 2'd0;
            busy_q     <= '0;
            inflight_q <= 6'd0;
            uf_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
            uf_q       <= uf_d;
        end
    end
    assign busy_mask     = busy_q;
    assign inflight      = inflight_q;
    assign underflow_err = uf_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed vectors with a queue-based scoreboard checked at each falling edge.
module tb_reg_scoreboard;
    logic        clk = 1'b0, rst = 1'b1;
    logic        issue_valid = 1'b0, use_src2 = 1'b0, wr_en = 1'b0, wb_valid = 1'b0, flush = 1'b0;
    logic [3:0]  src1 = '0, src2 = '0, dest = '0, wb_dest = '0;
    logic        issue_ready, stall, underflow_err;
    logic [14:0] busy_mask;
    logic [5:0]  inflight;
    int          checks = 0, errors = 0;

    typedef struct {
        string       name;
        logic        st;
        logic        rd;
        logic [14:0] bm;
        logic [5:0]  inf;
        logic        uf;
    } exp_t;
    exp_t exp_q[$];

    reg_scoreboard dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .src1(src1), .src2(src2),
        .use_src2(use_src2), .wr_en(wr_en), .dest(dest), .issue_ready(issue_ready),
        .stall(stall), .wb_valid(wb_valid), .wb_dest(wb_dest), .flush(flush),
        .busy_mask(busy_mask), .inflight(inflight), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (stall !== e.st || issue_ready !== e.rd || busy_mask !== e.bm
                || inflight !== e.inf || underflow_err !== e.uf) begin
                errors++;
                $display("FAIL %s: got stall=%b ready=%b busy=%h infl=%0d uf=%b, want stall=%b ready=%b busy=%h infl=%0d uf=%b",
                         e.name, stall, issue_ready, busy_mask, inflight, underflow_err,
                         e.st, e.rd, e.bm, e.inf, e.uf);
            end
        end
    end

    task automatic step(input string n, input logic iv, input logic [3:0] s1, s2, input logic us2,
                        input logic we, input logic [3:0] d, input logic wbv, input logic [3:0] wbd,
                        input logic fl, input logic est, erd, input logic [14:0] ebm,
                        input logic [5:0] einf, input logic euf, input logic arst = 1'b0);
        exp_t e;
        issue_valid = iv; src1 = s1; src2 = s2; use_src2 = us2; wr_en = we; dest = d;
        wb_valid = wbv; wb_dest = wbd; flush = fl;
        e.name = n; e.st = est; e.rd = erd; e.bm = ebm; e.inf = einf; e.uf = euf;
        exp_q.push_back(e);
        if (arst) begin
            #1 rst = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        //   name            iv s1 s2 u2 we d  wv wd fl  st rd busy      inf uf
        step("reset_hold",   1, 3, 0, 0, 1, 3, 0, 0, 0,  0, 1, 15'h0000, 0, 0);
        rst = 1'b0;
        step("idle",         0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 15'h0000, 0, 0);
        step("iss_d3",       1, 0, 0, 0, 1, 3, 0, 0, 0,  0, 1, 15'h0000, 0, 0);
        step("raw_s3",       1, 3, 0, 0, 0, 0, 0, 0, 0,  1, 0, 15'h0008, 1, 0);
        step("bypass_s3",    1, 3, 0, 0, 0, 0, 1, 3, 0,  0, 1, 15'h0008, 1, 0);
        step("after_wb3",    0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 15'h0000, 0, 0);
        step("d5_1",         1, 0, 0, 0, 1, 5, 0, 0, 0,  0, 1, 15'h0000, 0, 0);
        step("d5_2",         1, 0, 0, 0, 1, 5, 0, 0, 0,  0, 1, 15'h0020, 1, 0);
        step("d5_3",         1, 0, 0, 0, 1, 5, 0, 0, 0,  0, 1, 15'h0020, 2, 0);
        step("d5_cap",       1, 0, 0, 0, 1, 5, 0, 0, 0,  1, 0, 15'h0020, 3, 0);
        step("d5_cap_wb",    1, 0, 0, 0, 1, 5, 1, 5, 0,  0, 1, 15'h0020, 3, 0);
        step("d5_hold",      0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 15'h0020, 3, 0);
        step("src2_unused",  1, 0, 5, 0, 0, 0, 0, 0, 0,  0, 1, 15'h0020, 3, 0);
        step("src2_used",    1, 0, 5, 1, 0, 0, 0, 0, 0,  1, 0, 15'h0020, 3, 0);
        step("nobypass_c3",  1, 5, 0, 0, 0, 0, 1, 5, 0,  1, 0, 15'h0020, 3, 0);
        step("r15_a",        1,15,15, 1, 1,15, 0, 0, 0,  0, 1, 15'h0020, 2, 0);
        step("r15_b",        1,15, 0, 0, 1,15, 1,15, 0,  0, 1, 15'h0020, 2, 0);
        step("r15_c",        0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 15'h0020, 2, 0);
        step("wb5_a",        0, 0, 0, 0, 0, 0, 1, 5, 0,  0, 0, 15'h0020, 2, 0);
        step("wb5_b",        0, 0, 0, 0, 0, 0, 1, 5, 0,  0, 0, 15'h0020, 1, 0);
        step("empty",        0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 15'h0000, 0, 0);
        step("uf_wb7",       0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 0, 15'h0000, 0, 0);
        step("uf_set",       0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 15'h0000, 0, 1);
        step("iss_r1",       1, 0, 0, 0, 1, 1, 0, 0, 0,  0, 1, 15'h0000, 0, 1);
        step("iss_r2",       1, 0, 0, 0, 1, 2, 0, 0, 0,  0, 1, 15'h0002, 1, 1);
        step("flush",        1, 0, 0, 0, 1, 4, 1, 1, 1,  0, 1, 15'h0006, 2, 1);
        step("post_flush",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 15'h0000, 0, 1);
        step("iss_r6",       1, 0, 0, 0, 1, 6, 0, 0, 0,  0, 1, 15'h0000, 0, 1);
        step("async_rst",    0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 15'h0000, 0, 0, 1'b1);
        rst = 1'b0;
        step("post_rst",     0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 15'h0000, 0, 0);
        step("resume",       1, 6, 0, 0, 1, 6, 0, 0, 0,  0, 1, 15'h0000, 0, 0);
        step("resume_chk",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 15'h0040, 1, 0);
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
